// File: rtl/irq_capture_4_pkg.sv
// Shared constants and types for irq_capture_4.
// Optional feature macro: IRQ_SYNC_EN (two-flop input synchronizer).
package irq_capture_4_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Edges after reset during which the edge detector is disarmed, so a line
  // held high through reset (and its trip through the synchronizer) never
  // looks like a fresh 0->1 transition.
`ifdef IRQ_SYNC_EN
  localparam int ARM_N = 3;
`else
  localparam int ARM_N = 1;
`endif

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/irq_capture_4_if.sv
// Request/mask/dispatch bundle for irq_capture_4.
// master = request source + consumer side, slave = the capture block.
interface irq_capture_4_if;
  import irq_capture_4_pkg::*;
  logic               d0, d1, d2, d3;
  logic               mask_we;
  logic [NUM_REQ-1:0] mask_in;
  logic               ack;
  logic               valid;
  logic               q0, q1;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] ovr;

  modport master (output d0, d1, d2, d3, mask_we, mask_in, ack,
                  input  valid, q0, q1, pending, ovr);
  modport slave  (input  d0, d1, d2, d3, mask_we, mask_in, ack,
                  output valid, q0, q1, pending, ovr);
endinterface

// File: rtl/irq_capture_4_pri_enc.sv
// pri_enc_4to2: combinational 4-to-2 priority encoder, d3 highest.
// All-zero input encodes as 00; the caller qualifies with its own valid.
module pri_enc_4to2 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic q0,
  output logic q1
);
  logic unused_d0;
  assign unused_d0 = d0;  // lowest priority maps to 00, so d0 never drives a bit
  assign q1 = d3 | d2;
  assign q0 = d3 | (~d2 & d1);
endmodule

// File: rtl/irq_capture_4.sv
// irq_capture_4: rising-edge capture of four request lines into sticky
// pending bits, masked priority dispatch over a valid/ack handshake, and
// per-line overrun tracking.
// Optional feature macro: IRQ_SYNC_EN (two-flop synchronizer on each line).
module irq_capture_4
  import irq_capture_4_pkg::*;
#(
  parameter logic [NUM_REQ-1:0] MASK_RST = 4'b1111
) (
  input logic           clk,
  input logic           rst_n,
  irq_capture_4_if.slave bus
);
  logic [NUM_REQ-1:0] d_raw, d_src, prev, rise, clr, eff, mask, pend_q, ovr_q;
  logic [ARM_N-1:0]   arm;
  logic [IDX_W-1:0]   idx_q, idx_d, enc_idx;
  logic               enc_q0, enc_q1, ack_clr;
  state_t             state_q, state_d;

  assign d_raw = {bus.d3, bus.d2, bus.d1, bus.d0};

`ifdef IRQ_SYNC_EN
  logic [NUM_REQ-1:0] sync1, sync2;
  // Two-flop synchronizer ahead of edge detection.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d_raw;
      sync2 <= sync1;
    end
  assign d_src = sync2;
`else
  assign d_src = d_raw;
`endif

  // Previous-sample register plus post-reset arming delay.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0;
      arm  <= '0;
    end else begin
      prev <= d_src;
      arm  <= (arm << 1) | ARM_N'(1);
    end

  assign rise = d_src & ~prev & {NUM_REQ{arm[ARM_N-1]}};
  assign eff  = pend_q & mask;

  pri_enc_4to2 u_enc (eff[0], eff[1], eff[2], eff[3], enc_q0, enc_q1);
  assign enc_idx = {enc_q1, enc_q0};

  // Mask register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)           mask <= MASK_RST;
    else if (bus.mask_we) mask <= bus.mask_in;

  // Dispatch FSM state and latched index.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end

  // Next state: idx frozen while BUSY; ack outside BUSY is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_clr = 1'b0;
    case (state_q)
      IDLE: if (eff != '0) begin
        state_d = BUSY;
        idx_d   = enc_idx;
      end
      BUSY: if (bus.ack) begin
        state_d = IDLE;
        ack_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = ack_clr ? idx_onehot(idx_q) : '0;

  // Pending/overrun: a rise beats an ack clear for pending (event kept),
  // while the clear always wins for ovr on the acked line.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | rise;
      ovr_q  <= (ovr_q | (rise & pend_q)) & ~clr;
    end

  assign bus.valid   = (state_q == BUSY);
  assign bus.q0      = idx_q[0];
  assign bus.q1      = idx_q[1];
  assign bus.pending = pend_q;
  assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_irq_capture_4.sv
// Self-checking bench for irq_capture_4: event-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_irq_capture_4;
`ifdef IRQ_SYNC_EN
  localparam int SX  = 2;
  localparam int ARM = 3;
`else
  localparam int SX  = 0;
  localparam int ARM = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_capture_4_if bus ();
  irq_capture_4 #(.MASK_RST(4'b1111)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sets of pending/overrun lines, one outstanding dispatch.
  logic [3:0] m_pend, m_ovr, m_mask, m_prev, m_s1, m_s2;
  logic [3:0] m_dn, m_src, m_rise, m_eff, m_np, m_no;
  int         m_edges, m_idx, m_clr;
  bit         m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_ovr = 0; m_mask = 4'hF; m_prev = 0; m_s1 = 0; m_s2 = 0;
      m_edges = 0; m_idx = 0; m_busy = 0;
    end else begin
      m_dn  = {bus.d3, bus.d2, bus.d1, bus.d0};
      m_src = (SX != 0) ? m_s2 : m_dn;
      for (int i = 0; i < 4; i++)
        m_rise[i] = (m_edges >= ARM) && m_src[i] && !m_prev[i];
      m_clr = (m_busy && bus.ack) ? m_idx : -1;
      m_eff = m_pend & m_mask;
      for (int i = 0; i < 4; i++) begin
        m_no[i] = (m_ovr[i] || (m_rise[i] && m_pend[i])) && (i != m_clr);
        m_np[i] = (m_pend[i] && (i != m_clr)) || m_rise[i];
      end
      if (m_busy) begin
        if (bus.ack) m_busy = 0;
      end else if (m_eff != 0) begin
        for (int i = 0; i < 4; i++) if (m_eff[i]) m_idx = i;
        m_busy = 1;
      end
      m_pend = m_np; m_ovr = m_no; m_prev = m_src;
      m_s2 = m_s1; m_s1 = m_dn;
      if (bus.mask_we) m_mask = bus.mask_in;
      if (m_edges < 1000) m_edges++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (bus.valid !== m_busy || {bus.q1, bus.q0} !== 2'(m_idx) ||
          bus.pending !== m_pend || bus.ovr !== m_ovr) begin
        n_err++;
        $display("FAIL cycle t=%0t: got valid=%b q=%b%b pend=%b ovr=%b, want valid=%b q=%0d pend=%b ovr=%b",
                 $time, bus.valid, bus.q1, bus.q0, bus.pending, bus.ovr,
                 m_busy, m_idx, m_pend, m_ovr);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] v);
    {bus.d3, bus.d2, bus.d1, bus.d0} = v;
  endtask

  function automatic logic [3:0] vq();
    return {1'b0, bus.valid, bus.q1, bus.q0};
  endfunction

  typedef struct { logic [3:0] d; logic ack; logic we; logic [3:0] m; } row_t;
  row_t tbl [10];

  initial begin
    set_d(4'b1000); bus.ack = 0; bus.mask_we = 0; bus.mask_in = 4'hF;
    tbl[0] = '{4'b0101, 1'b1, 1'b0, 4'hF};
    tbl[1] = '{4'b0000, 1'b0, 1'b1, 4'b1010};
    tbl[2] = '{4'b1111, 1'b0, 1'b0, 4'hF};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 4'hF};
    tbl[4] = '{4'b0110, 1'b0, 1'b0, 4'hF};
    tbl[5] = '{4'b0000, 1'b1, 1'b1, 4'b0001};
    tbl[6] = '{4'b1001, 1'b1, 1'b0, 4'hF};
    tbl[7] = '{4'b0000, 1'b0, 1'b1, 4'hF};
    tbl[8] = '{4'b0010, 1'b1, 1'b0, 4'hF};
    tbl[9] = '{4'b0000, 1'b1, 1'b0, 4'hF};

    // Reset with d3 held high: no dispatch afterwards.
    tick(3);
    rst_n = 1;
    tick(6);
    chk("reset_valid_q", vq(), 4'b0000);
    chk("reset_pending", bus.pending, 4'b0000);
    chk("reset_ovr", bus.ovr, 4'b0000);
    set_d(0); tick(2 + SX);

    // Single request on d2.
    set_d(4'b0100); tick(1 + SX);
    chk("single_pending", bus.pending, 4'b0100);
    chk("single_not_yet_valid", vq(), 4'b0000);
    set_d(0); tick(1);
    chk("single_dispatch", vq(), 4'b0110);
    bus.ack = 1; tick(1); bus.ack = 0;
    chk("single_acked_pend", bus.pending, 4'b0000);
    chk("single_acked_valid", vq(), 4'b0010);

    // Priority: d0 and d3 together.
    set_d(4'b1001); tick(1 + SX); set_d(0); tick(1);
    chk("prio_first", vq(), 4'b0111);
    bus.ack = 1; tick(1); bus.ack = 0;
    chk("prio_gap", {3'b000, bus.valid}, 4'b0000);
    tick(1);
    chk("prio_second", vq(), 4'b0100);
    bus.ack = 1; tick(1); bus.ack = 0;

    // Mask: d3 latched but held back until unmasked.
    bus.mask_we = 1; bus.mask_in = 4'b0111; tick(1); bus.mask_we = 0;
    set_d(4'b1000); tick(1 + SX); set_d(0); tick(2);
    chk("mask_pending", bus.pending, 4'b1000);
    chk("mask_held", {3'b000, bus.valid}, 4'b0000);
    bus.mask_we = 1; bus.mask_in = 4'hF; tick(1); bus.mask_we = 0;
    tick(1);
    chk("mask_release", vq(), 4'b0111);
    bus.ack = 1; tick(1); bus.ack = 0;

    // Overrun, then set-wins on the ack edge.
    set_d(4'b0010); tick(1 + SX); set_d(0); tick(1);
    chk("ovr_dispatch", vq(), 4'b0101);
    set_d(4'b0010); tick(1 + SX);
    chk("ovr_flag", bus.ovr, 4'b0010);
    set_d(0); tick(1 + SX);
    set_d(4'b0010); tick(SX);
    bus.ack = 1; tick(1); bus.ack = 0; set_d(0);
    chk("setwins_pending", bus.pending, 4'b0010);
    chk("setwins_ovr", bus.ovr, 4'b0000);
    chk("setwins_gap", {3'b000, bus.valid}, 4'b0000);
    tick(1);
    chk("setwins_redispatch", vq(), 4'b0101);
    bus.ack = 1; tick(1); bus.ack = 0;
    tick(1 + SX);

    // Directed burst, checked by the per-cycle compare.
    for (int r = 0; r < 10; r++) begin
      set_d(tbl[r].d); bus.ack = tbl[r].ack;
      bus.mask_we = tbl[r].we; bus.mask_in = tbl[r].m;
      tick(1);
    end
    set_d(0); bus.mask_we = 0; bus.ack = 1; tick(8 + SX); bus.ack = 0;

    // Reset mid-BUSY drops the transaction at once.
    set_d(4'b0001); tick(2 + SX);
    chk("midbusy_valid", vq(), 4'b0100);
    rst_n = 0; #1;
    chk("midbusy_reset_valid", {3'b000, bus.valid}, 4'b0000);
    tick(2); rst_n = 1; tick(3 + SX);
    chk("after_reset_pending", bus.pending, 4'b0000);
    chk("after_reset_valid", {3'b000, bus.valid}, 4'b0000);
    set_d(0); tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/irq_capture_4.md
# irq_capture_4

Four-line request capture and dispatch stage feeding the `pri_enc_4to2` priority encoder. It detects rising edges on four asynchronous request lines and latches them into sticky pending bits. It applies a mask, encodes the highest-priority pending request, and presents the 2-bit index to a downstream consumer through a valid/ack handshake. It owns the sequential behaviour around the combinational encoder: capture, hold, clear and overrun tracking.

## Interface
- `MASK_RST`, default 4'b1111: reset value of the mask register (1 = line enabled).
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: reset, asynchronous and active-low.
- `d0`..`d3` input 1 each: request lines, `d3` highest priority.
- `mask_we` input 1: mask write strobe.
- `mask_in` input 4: new mask value, bit i gates `di`.
- `ack` input 1: consumer accepts the presented index.
- `valid` output 1: index `q1:q0` is valid.
- `q0`, `q1` output 1 each: encoded index, `q1` is the MSB.
- `pending` output 4: raw pending register, unmasked.
- `ovr` output 4: sticky per-line overrun flags.

## Operation
- **Edge detect.** `rise[i] = di & ~prev[i]`, where `prev` is the registered previous sample of `di`.
- **Pending set.** Each rise sets `pending[i]`. Masked lines still latch pending; they are not presented until unmasked.
- **Overrun.** A rise on a line whose `pending[i]` is already 1 sets `ovr[i]`.
- **Masked view.** `eff = pending & mask` drives the `pri_enc_4to2` instance (`d0`..`d3` → `q0`, `q1`). `d3` has the highest priority, `d0` the lowest.
- **State machine** (two states):
  - IDLE: `valid` = 0. If `eff` != 0, register the encoder output into `idx`, go to BUSY, and set `valid` = 1.
  - BUSY: `valid` = 1 and `idx` is held stable regardless of new requests or mask changes. On `ack`, clear `pending[idx]` and `ovr[idx]`, then return to IDLE.
  - `ack` in IDLE is ignored.
- **Simultaneous rise and clear.** If a rise on line `idx` coincides with the ack clear of that line, set wins: `pending[idx]` stays 1 and `ovr[idx]` is cleared. The new event is not lost.
- **Mask write.** `mask_we` updates the mask at the clock edge. A line masked while it is being presented in BUSY does not abort the transaction.
- **Reset state.** `pending`, `ovr`, `prev`, `idx` = 0; mask = `MASK_RST`; state = IDLE. Therefore `valid` = 0 and `q0`/`q1` = 0.
- **Reset mid-transaction.** The transaction is dropped and no ack is required. The rise detector only fires on a new 0→1 transition after reset; a line held high through reset does not fire.

## Timing
- A line sampled high at edge k and low at edge k-1 sets `pending` at edge k.
- Baseline, edges counted from the sampling edge k:
  - `pending[i]` visible after edge k.
  - `valid` and index visible after edge k+1 (2-edge latency).
- `ack` is sampled at the clock edge while `valid` = 1:
  - `valid` drops after that edge, with a minimum one-cycle IDLE gap.
  - The next index is presented no earlier than 2 edges after the ack edge.
- Peak throughput: one dispatch per 2 cycles.
- `pending` and `ovr` outputs are registered; `valid`, `q0` and `q1` are registered.

## Configuration
- `IRQ_SYNC_EN` defined:
  - A two-flop synchronizer sits on each `di` ahead of edge detection.
  - Adds 2 cycles: `valid` appears after edge k+3, where k is now the first edge at which the first synchronizer flop samples the line high.
  - Synchronizer flops reset to 0.
- `IRQ_SYNC_EN` undefined: `di` feed edge detection directly; `di` must already be synchronous to `clk`.

## Structure
- Shared package constants:
  - state encoding: IDLE = 1'b0, BUSY = 1'b1;
  - `NUM_REQ` = 4;
  - `IDX_W` = 2.
- Sub-module: one instance of the existing `pri_enc_4to2`, connected with positional order (`d0`, `d1`, `d2`, `d3`, `q0`, `q1`).
- No other sub-modules; the synchronizer is inline under the macro.

## Test plan
- **Reset.** Assert `rst_n` = 0 with `d3` = 1. Release. Then `valid` = 0, `q1:q0` = 00, `pending` = 0000, and no dispatch while `d3` is held high.
- **Single request.** Pulse `d2` 0→1 at edge k, with no sync. After edge k+1: `valid` = 1, `q1:q0` = 10. Ack → `pending` = 0000, `valid` = 0.
- **Priority.** Raise `d0` and `d3` at the same edge. First dispatch `q1:q0` = 11. After ack, next dispatch `q1:q0` = 00, two edges later.
- **Mask.** Write `mask_in` = 4'b0111, then pulse `d3`. Then `pending` = 1000 and `valid` stays 0. Write mask 1111 → `valid` = 1 with 11 two edges later.
- **Overrun and set-wins.**
  - Pulse `d1` twice before any ack → `ovr` = 0010.
  - Re-pulse `d1` on the ack edge → `pending[1]` = 1, `ovr[1]` = 0, and a second dispatch of 01.
- **Synchronizer, `IRQ_SYNC_EN` build.** The single-request case yields `valid` after edge k+3. Repeat the reset-mid-BUSY case: `valid` falls immediately when `rst_n` goes low.
